hilbert_channel_scheduler: RTL and testbench
============================================

# hilbert_channel_scheduler

Time-multiplexes one shared Hilbert-transformer datapath across `NUM_CH` sample channels. On each sample tick it latches all channel samples and issues them one at a time to the datapath with a one-cycle strobe. It waits for each `done`, collects the results, and publishes the whole frame with a single valid pulse. It sits between the ADC sample fan-out and the shared `HilbertTransformer`, which keeps per-channel history banks selected by `dp_chan_o`.

## Interface

Parameters:
- `NUM_CH`, 4: number of channels (≥2).
- `WIDTH`, 24: signed sample width.
- `MAX_WAIT`, 1023: maximum WAIT cycles per channel before timeout (≥2).

Ports:
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `tick_i`  in  1  one-cycle sample strobe; `signal_i` is valid in the same cycle.
- `signal_i`  in  NUM_CH*WIDTH  packed signed samples, channel 0 in the LSBs.
- `clear_i`  in  1  clears the sticky flags.
- `dp_tick_o`  out  1  strobe to the shared datapath.
- `dp_chan_o`  out  $clog2(NUM_CH)  channel / history-bank select.
- `dp_signal_o`  out  WIDTH  sample issued to the datapath.
- `dp_signal_i`  in  WIDTH  datapath result.
- `dp_done_i`  in  1  datapath result valid.
- `signal_o`  out  NUM_CH*WIDTH  packed results of the last completed frame.
- `valid_o`  out  1  one-cycle pulse when `signal_o` updates.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `overrun_o`  out  1  sticky: `tick_i` arrived while busy.
- `timeout_o`  out  1  sticky: a channel hit `MAX_WAIT`.

## Operation

State machine: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** when `tick_i` is high, latch all `signal_i` lanes into the hold registers, set ch=0, go to ISSUE.
- **ISSUE (1 cycle):**
  - `dp_tick_o`=1, `dp_chan_o`=ch, `dp_signal_o`=hold[ch].
  - Clear the wait counter, go to WAIT.
- **WAIT:**
  - If `dp_done_i` is high: result[ch] ← `dp_signal_i`.
  - Else if the wait counter = MAX_WAIT−1: result[ch] is left unchanged (stale) and `timeout_o` is set.
  - Else: increment the wait counter and stay.
  - On done or timeout: if ch = NUM_CH−1 go to DONE, else ch+1 and go to ISSUE.
- **DONE (1 cycle):** `signal_o` ← all result registers; `valid_o` ← 1 (registered); go to IDLE.

Input handling:
- `dp_done_i` is ignored outside WAIT.
- `tick_i` is ignored outside IDLE and sets `overrun_o`.

Outputs and flags:
- `dp_chan_o` and `dp_signal_o` hold their last values outside ISSUE.
- `dp_tick_o` is a Moore decode of ISSUE.
- Sticky flags: a set takes priority over `clear_i` in the same cycle.
- Data is a pure pass-through with no arithmetic; signed values, including −2^(WIDTH−1), are preserved bit-exact.

## Timing

Reset (synchronous):
- The cycle after `reset_i` is sampled high: state=IDLE, ch=0.
- Hold, result, `signal_o`, `dp_signal_o` and `dp_chan_o` are 0.
- All 1-bit outputs are 0.
- Reset mid-frame abandons the frame with no `valid_o`.

Latency, with `tick_i` sampled in cycle 0 and the datapath answering L cycles after its strobe (L ≥ 1):
- ISSUE for channel k falls in cycle 1 + k·(L+1); its done is sampled in cycle 1 + k·(L+1) + L.
- DONE falls in cycle NUM_CH·(L+1) + 1.
- `valid_o` and the new `signal_o` appear in cycle NUM_CH·(L+1) + 2.
- Example: NUM_CH=4, L=1 gives `valid_o` in cycle 10.

Boundary cases:
- A timeout channel occupies exactly MAX_WAIT WAIT cycles.
- `tick_i` in the same cycle as `valid_o` is accepted, because the state is already IDLE: no overrun, no gap.
- `tick_i` in the DONE cycle counts as an overrun.
- `signal_o` is stable between `valid_o` pulses.

## Test plan

1. **Nominal frame.** NUM_CH=4, L=1, model returns −x. Inputs 100, −200, 300, −400, tick in cycle 0.
   - Required: `dp_tick_o` in cycles 1, 3, 5, 7 with `dp_chan_o` 0..3.
   - Required: `valid_o` only in cycle 10, `signal_o` = −100, 200, −300, 400.
2. **Overrun.** Extra `tick_i` in cycle 4 with different data.
   - Required: `overrun_o`=1 from cycle 5, frame results unchanged, no second frame.
   - Required: `clear_i` in cycle 12 gives `overrun_o`=0 in cycle 13.
3. **Timeout.** MAX_WAIT=8; model never answers channel 2; previous frame left result[2]=55.
   - Required: channel 2 spends 8 WAIT cycles, `timeout_o`=1, `valid_o` still pulses.
   - Required: `signal_o` lane 2 = 55, other lanes fresh.
4. **Reset mid-frame.** `reset_i` in cycle 4.
   - Required: in cycle 5 all outputs are 0 and `busy_o`=0; no `valid_o`.
   - Required: a new tick in cycle 6 runs a full frame with `valid_o` in cycle 16.
5. **Back-to-back.** Second tick in cycle 10, coincident with `valid_o`.
   - Required: accepted, `overrun_o` stays 0, second `valid_o` in cycle 20.
6. **Extremes, spurious done.** Samples −8388608 and 8388607 with an identity model; `dp_done_i` pulses while in IDLE.
   - Required: outputs bit-exact, spurious done ignored, no state change.

Source files
------------

// File: rtl/hilbert_channel_scheduler.sv
// hilbert_channel_scheduler
//
// Shares one Hilbert-transformer datapath across NUM_CH sample channels.
// On each sample tick, all channel samples are latched. They are issued one
// at a time to the datapath with a one-cycle strobe. The scheduler waits for
// each result, with a bounded wait, and then publishes the whole frame with a
// single valid pulse.
//
// Ports:
//   clk_i        single clock
//   reset_i      synchronous active-high reset
//   tick_i       sample strobe, signal_i valid in the same cycle
//   signal_i     packed signed samples, channel 0 in the LSBs
//   clear_i      clears the sticky overrun/timeout flags
//   dp_tick_o    one-cycle strobe to the shared datapath
//   dp_chan_o    channel / history-bank select for the datapath
//   dp_signal_o  sample issued to the datapath
//   dp_signal_i  datapath result
//   dp_done_i    datapath result valid (only honoured while waiting)
//   signal_o     packed results of the last completed frame
//   valid_o      one-cycle pulse when signal_o updates
//   busy_o       high whenever a frame is in progress
//   overrun_o    sticky: tick_i arrived while busy
//   timeout_o    sticky: a channel ran out of wait cycles
module hilbert_channel_scheduler #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned MAX_WAIT = 1023
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tick_i,
    input  logic [NUM_CH*WIDTH-1:0]    signal_i,
    input  logic                       clear_i,
    output logic                       dp_tick_o,
    output logic [$clog2(NUM_CH)-1:0]  dp_chan_o,
    output logic [WIDTH-1:0]           dp_signal_o,
    input  logic [WIDTH-1:0]           dp_signal_i,
    input  logic                       dp_done_i,
    output logic [NUM_CH*WIDTH-1:0]    signal_o,
    output logic                       valid_o,
    output logic                       busy_o,
    output logic                       overrun_o,
    output logic                       timeout_o
);

    localparam int unsigned CHW = $clog2(NUM_CH);
    // Counter only needs to reach MAX_WAIT-1.
    localparam int unsigned WW  = $clog2(MAX_WAIT);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]                         state_q, state_d;
    logic [CHW-1:0]                     ch_q, ch_d;
    logic [WW-1:0]                      wait_q, wait_d;
    logic [NUM_CH-1:0][WIDTH-1:0]       hold_q, hold_d;
    logic [NUM_CH-1:0][WIDTH-1:0]       result_q, result_d;
    logic [NUM_CH*WIDTH-1:0]            signal_q, signal_d;
    logic                               valid_q, valid_d;
    logic [CHW-1:0]                     dp_chan_q, dp_chan_d;
    logic [WIDTH-1:0]                   dp_signal_q, dp_signal_d;
    logic                               overrun_q, overrun_d;
    logic                               timeout_q, timeout_d;

    logic                               advance;
    logic                               timeout_set;
    logic                               overrun_set;
    logic [CHW-1:0]                     ch_inc;

    assign ch_inc      = ch_q + CHW'(1);
    assign overrun_set = tick_i && (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wait_d      = wait_q;
        hold_d      = hold_q;
        result_d    = result_q;
        signal_d    = signal_q;
        valid_d     = 1'b0;
        dp_chan_d   = dp_chan_q;
        dp_signal_d = dp_signal_q;
        advance     = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            StIdle: begin
                if (tick_i) begin
                    hold_d      = signal_i;
                    ch_d        = '0;
                    // Datapath outputs are registered, so load them on entry to ISSUE.
                    dp_chan_d   = '0;
                    dp_signal_d = signal_i[WIDTH-1:0];
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                wait_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (dp_done_i) begin
                    result_d[ch_q] = dp_signal_i;
                    advance        = 1'b1;
                end else if (wait_q == WW'(MAX_WAIT - 1)) begin
                    // The result lane keeps its stale value from the previous frame.
                    timeout_set = 1'b1;
                    advance     = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end

                if (advance) begin
                    if (ch_q == CHW'(NUM_CH - 1)) begin
                        state_d = StDone;
                    end else begin
                        ch_d        = ch_inc;
                        dp_chan_d   = ch_inc;
                        dp_signal_d = hold_q[ch_inc];
                        state_d     = StIssue;
                    end
                end
            end
            StDone: begin
                signal_d = result_q;
                valid_d  = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A set wins over a clear that arrives in the same cycle.
        overrun_d = overrun_set | (overrun_q & ~clear_i);
        timeout_d = timeout_set | (timeout_q & ~clear_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            wait_q      <= '0;
            hold_q      <= '0;
            result_q    <= '0;
            signal_q    <= '0;
            valid_q     <= 1'b0;
            dp_chan_q   <= '0;
            dp_signal_q <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wait_q      <= wait_d;
            hold_q      <= hold_d;
            result_q    <= result_d;
            signal_q    <= signal_d;
            valid_q     <= valid_d;
            dp_chan_q   <= dp_chan_d;
            dp_signal_q <= dp_signal_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign dp_tick_o   = (state_q == StIssue);
    assign dp_chan_o   = dp_chan_q;
    assign dp_signal_o = dp_signal_q;
    assign signal_o    = signal_q;
    assign valid_o     = valid_q;
    assign busy_o      = (state_q != StIdle);
    assign overrun_o   = overrun_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_hilbert_channel_scheduler.sv
// Testbench for hilbert_channel_scheduler: table-driven frames plus
// hand-written overrun, timeout, reset, back-to-back and spurious-done sequences.
module tb_hilbert_channel_scheduler;

    localparam int NCH       = 4;
    localparam int W         = 24;
    localparam int MAXW      = 8;
    localparam int LAT       = 1;
    localparam int FRAME_LAT = NCH * (LAT + 1) + 2;
    localparam int TOUT_LAT  = (NCH - 1) * (LAT + 1) + 1 + MAXW + 2;

    logic              clk;
    logic              reset_i;
    logic              tick_i;
    logic [NCH*W-1:0]  signal_i;
    logic              clear_i;
    logic              dp_tick_o;
    logic [1:0]        dp_chan_o;
    logic [W-1:0]      dp_signal_o;
    logic [W-1:0]      dp_signal_i;
    logic              dp_done_i;
    logic [NCH*W-1:0]  signal_o;
    logic              valid_o;
    logic              busy_o;
    logic              overrun_o;
    logic              timeout_o;

    hilbert_channel_scheduler #(
        .NUM_CH   (NCH),
        .WIDTH    (W),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .tick_i      (tick_i),
        .signal_i    (signal_i),
        .clear_i     (clear_i),
        .dp_tick_o   (dp_tick_o),
        .dp_chan_o   (dp_chan_o),
        .dp_signal_o (dp_signal_o),
        .dp_signal_i (dp_signal_i),
        .dp_done_i   (dp_done_i),
        .signal_o    (signal_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH*W-1:0] sig;
        logic             ident;
        logic [NCH*W-1:0] exp;
    } vec_t;

    typedef struct packed {
        logic [NCH*W-1:0] data;
        int               cyc;
    } exp_t;

    vec_t        vecs[4];
    exp_t        sb[$];
    int          iss_cyc[$];
    int          iss_ch[$];
    logic [W-1:0] iss_sig[$];

    int          npass = 0;
    int          ntot  = 0;
    int          cyc   = 0;
    int          nvalid = 0;
    int          t0;
    int          nv0;

    // Datapath model state
    logic        ident = 1'b0;
    int          skip_ch = -1;
    logic        spurious = 1'b0;
    logic [W-1:0] spur_val = 24'h123456;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [W-1:0] psig = '0;
    logic [W-1:0] res = '0;

    function automatic logic [NCH*W-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntot++;
        if (act !== exp) begin
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end else begin
            npass++;
        end
    endtask

    // Advance one clock; sample at #1 after the edge, then drive this cycle's inputs.
    task automatic cycle();
        logic done_now;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        tick_i  = 1'b0;
        clear_i = 1'b0;
        reset_i = 1'b0;

        done_now = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                done_now = 1'b1;
                res  = ident ? psig : (~psig + 24'd1);
                pend = 1'b0;
            end
        end
        if (dp_tick_o) begin
            iss_cyc.push_back(cyc);
            iss_ch.push_back(int'(dp_chan_o));
            iss_sig.push_back(dp_signal_o);
            if (int'(dp_chan_o) != skip_ch) begin
                pend = 1'b1;
                cnt  = LAT;
                psig = dp_signal_o;
            end
        end
        dp_done_i   = spurious ? 1'b1 : done_now;
        dp_signal_i = spurious ? spur_val : res;

        if (valid_o) begin
            nvalid++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 128'(valid_o), 128'd0);
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", 128'(cyc), 128'(e.cyc));
                chk("frame_data", 128'(signal_o), 128'(e.data));
            end
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) cycle();
    endtask

    task automatic start(input logic [NCH*W-1:0] sig, input logic id,
                         input logic [NCH*W-1:0] e, input int lat);
        exp_t x;
        signal_i = sig;
        tick_i   = 1'b1;
        ident    = id;
        t0       = cyc;
        nv0      = nvalid;
        x.data   = e;
        x.cyc    = cyc + lat;
        sb.push_back(x);
        iss_cyc.delete();
        iss_ch.delete();
        iss_sig.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, 128'({dp_tick_o, valid_o, busy_o, overrun_o, timeout_o}), 128'd0);
        chk({tag, "_data"}, 128'({signal_o, dp_signal_o, dp_chan_o}), 128'd0);
    endtask

    initial begin
        vecs[0] = '{sig: pk(100, -200, 300, -400), ident: 1'b0, exp: pk(-100, 200, -300, 400)};
        vecs[1] = '{sig: pk(-8388608, 8388607, 0, -1), ident: 1'b1,
                    exp: pk(-8388608, 8388607, 0, -1)};
        vecs[2] = '{sig: pk(1, -1, 8388607, 123456), ident: 1'b0,
                    exp: pk(-1, 1, -8388607, -123456)};
        vecs[3] = '{sig: pk(7, 0, -5, 42), ident: 1'b1, exp: pk(7, 0, -5, 42)};

        reset_i = 1'b1;
        tick_i = 1'b0;
        clear_i = 1'b0;
        signal_i = '0;
        dp_signal_i = '0;
        dp_done_i = 1'b0;
        cycle();
        chk_zero("reset");

        // Table-driven frames: issue schedule, pass-through and single valid.
        for (int i = 0; i < 4; i++) begin
            run_to(cyc + 2);
            start(vecs[i].sig, vecs[i].ident, vecs[i].exp, FRAME_LAT);
            run_to(t0 + 14);
            chk("issue_count", 128'(iss_cyc.size()), 128'(NCH));
            if (iss_cyc.size() == NCH) begin
                for (int k = 0; k < NCH; k++) begin
                    chk("issue_cycle", 128'(iss_cyc[k]), 128'(t0 + 1 + k * (LAT + 1)));
                    chk("issue_chan", 128'(iss_ch[k]), 128'(k));
                    chk("issue_sig", 128'(iss_sig[k]), 128'(vecs[i].sig[k*W +: W]));
                end
            end
            chk("frame_valid_count", 128'(nvalid - nv0), 128'd1);
            chk("frame_idle", 128'(busy_o), 128'd0);
            chk("frame_stable", 128'(signal_o), 128'(vecs[i].exp));
        end

        // Overrun: extra tick mid-frame is ignored but flagged.
        start(pk(5, 6, 7, 8), 1'b0, pk(-5, -6, -7, -8), FRAME_LAT);
        run_to(t0 + 4);
        signal_i = pk(99, 99, 99, 99);
        tick_i = 1'b1;
        chk("overrun_before", 128'(overrun_o), 128'd0);
        cycle();
        chk("overrun_set", 128'(overrun_o), 128'd1);
        run_to(t0 + 12);
        clear_i = 1'b1;
        cycle();
        chk("overrun_clear", 128'(overrun_o), 128'd0);
        run_to(t0 + 30);
        chk("overrun_one_frame", 128'(nvalid - nv0), 128'd1);
        chk("overrun_idle", 128'(busy_o), 128'd0);

        // Timeout: seed result[2]=55, then never answer channel 2.
        start(pk(10, 20, -55, 30), 1'b0, pk(-10, -20, 55, -30), FRAME_LAT);
        run_to(t0 + 14);
        skip_ch = 2;
        start(pk(1, 2, 3, 4), 1'b0, pk(-1, -2, 55, -4), TOUT_LAT);
        run_to(t0 + 13);
        chk("timeout_before", 128'(timeout_o), 128'd0);
        cycle();
        chk("timeout_set", 128'(timeout_o), 128'd1);
        chk("timeout_next_issue", 128'({dp_tick_o, dp_chan_o}), 128'({1'b1, 2'd3}));
        run_to(t0 + 22);
        chk("timeout_valid_count", 128'(nvalid - nv0), 128'd1);
        skip_ch = -1;
        clear_i = 1'b1;
        cycle();
        chk("timeout_clear", 128'(timeout_o), 128'd0);

        // Reset mid-frame abandons the frame.
        start(pk(11, 12, 13, 14), 1'b0, pk(-11, -12, -13, -14), FRAME_LAT);
        run_to(t0 + 4);
        reset_i = 1'b1;
        cycle();
        chk_zero("midreset");
        pend = 1'b0;
        dp_done_i = 1'b0;
        void'(sb.pop_back());
        nv0 = nvalid;
        cycle();
        start(pk(21, -22, 23, -24), 1'b1, pk(21, -22, 23, -24), FRAME_LAT);
        run_to(t0 + 20);
        chk("reset_restart_valid_count", 128'(nvalid - nv0), 128'd1);

        // Back-to-back: tick coincident with valid_o.
        start(pk(31, 32, 33, 34), 1'b0, pk(-31, -32, -33, -34), FRAME_LAT);
        run_to(t0 + FRAME_LAT);
        start(pk(41, 42, 43, 44), 1'b0, pk(-41, -42, -43, -44), FRAME_LAT);
        nv0 = nvalid - 1;
        cycle();
        chk("b2b_no_overrun", 128'(overrun_o), 128'd0);
        chk("b2b_busy", 128'(busy_o), 128'd1);
        run_to(t0 + 22);
        chk("b2b_no_overrun_end", 128'(overrun_o), 128'd0);
        chk("b2b_valid_count", 128'(nvalid - nv0), 128'd2);

        // Spurious done while idle is ignored.
        nv0 = nvalid;
        spurious = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("spur_idle", 128'({busy_o, valid_o, dp_tick_o}), 128'd0);
        end
        spurious = 1'b0;
        cycle();
        cycle();
        chk("spur_signal_kept", 128'(signal_o), 128'(pk(-41, -42, -43, -44)));
        chk("spur_no_valid", 128'(nvalid - nv0), 128'd0);
        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
